// File: rtl/rsff_chk_pkg.sv
// Shared types and constants for the RS flip-flop response checker.
package rsff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {s,r} input codes of the RS characteristic table
  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RST    = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] FORBID = 2'b11;

endpackage

// File: rtl/rsff_golden_model.sv
// Combinational RS characteristic table: {s,r,q_in} -> expected next state.
module rsff_golden_model
  import rsff_chk_pkg::*;
(
  input  logic s,
  input  logic r,
  input  logic q_in,
  output logic expected_q,
  output logic forbidden
);

  always_comb begin
    expected_q = 1'b0;
    forbidden  = 1'b0;
    case ({s, r})
      HOLD:   expected_q = q_in;
      RST:    expected_q = 1'b0;
      SET:    expected_q = 1'b1;
      FORBID: forbidden  = 1'b1;
    endcase
  end

endmodule

// File: rtl/rsff_response_checker.sv
// Checks RS flip-flop responses against the characteristic table and keeps run statistics.
// Optional first-failure capture ports: define RSFF_CHK_FIRST_FAIL_CAPTURE_EN.
module rsff_response_checker
  import rsff_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic             s,
  input  logic             r,
  input  logic             q_in,
  input  logic             q_out,
  input  logic             q_out_bar,
  output logic             mismatch,
  output logic             error_sticky,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] forbidden_count,
  output logic [CNT_W-1:0] vec_index,
`ifdef RSFF_CHK_FIRST_FAIL_CAPTURE_EN
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [4:0]       first_fail_vec,
`endif
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state, state_nxt;
  logic   expected_q, forbidden;
  logic   accept, last_vec, pass_now, fail_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  rsff_golden_model u_golden (
    .s          (s),
    .r          (r),
    .q_in       (q_in),
    .expected_q (expected_q),
    .forbidden  (forbidden)
  );

  assign accept   = valid && (state != DONE);
  assign last_vec = (vec_index == LAST_IDX);
  assign pass_now = !forbidden && (q_out == expected_q) && (q_out_bar != q_out);
  assign fail_now = !forbidden && !pass_now;
  assign done     = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // IDLE consumes the first vector on the same edge it leaves, so NUM_VECTORS=1 goes straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = last_vec ? DONE : RUN;
      RUN:     if (valid && last_vec) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mismatch        <= 1'b0;
      error_sticky    <= 1'b0;
      pass_count      <= '0;
      fail_count      <= '0;
      forbidden_count <= '0;
      vec_index       <= '0;
    end else begin
      mismatch <= accept && fail_now;
      if (accept) begin
        vec_index <= sat_inc(vec_index);
        if (forbidden)     forbidden_count <= sat_inc(forbidden_count);
        else if (pass_now) pass_count      <= sat_inc(pass_count);
        else begin
          fail_count   <= sat_inc(fail_count);
          error_sticky <= 1'b1;
        end
      end
    end
  end

`ifdef RSFF_CHK_FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      first_fail_idx <= '0;
      first_fail_vec <= '0;
    end else if (accept && fail_now && !error_sticky) begin
      first_fail_idx <= vec_index;
      first_fail_vec <= {s, r, q_in, q_out, q_out_bar};
    end
  end
`endif

endmodule
